// File: rtl/spi_slave_gen.sv
// SPI slave: deserialises MOSI frames into {cmd, payload} words and serialises read data onto MISO.
// Optional short-frame / tx-timeout error pulse is built when SPI_SLV_FRAME_ERR_EN is defined.
module spi_slave_gen #(
   parameter int DATA_W      = 8,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int TX_WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              busy,
   output logic              frame_err
);

   localparam int CW = $clog2(DATA_W + 2);
   localparam int WW = $clog2(TX_WAIT_MAX + 1);
   localparam logic [CW-1:0] LAST  = CW'(DATA_W + 1);
   localparam logic [CW-1:0] TXL   = CW'(DATA_W - 1);
   localparam logic [WW-1:0] WLAST = WW'(TX_WAIT_MAX - 1);

   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
   typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_SEND, PH_DONE} phase_t;

   state_t            state, state_nxt;
   phase_t            phase;
   logic [CW-1:0]     cnt;
   logic [WW-1:0]     wcnt;
   logic [1:0]        cmd_sh;
   logic [DATA_W-1:0] pay_sh, pay_nxt;
   logic [DATA_W-1:0] tx_sh, tx_nxt;
   logic              tx_bit;
   logic              rd_addr_seen;
   logic              in_rx, last_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (SS_n) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = CHK_CMD;
            CHK_CMD: begin
               if (!MOSI)             state_nxt = WRITE;
               else if (rd_addr_seen) state_nxt = READ_DATA;
               else                   state_nxt = READ_ADD;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      in_rx    = (state == WRITE || state == READ_ADD || state == READ_DATA) && (phase == PH_RX);
      last_bit = in_rx && (cnt == LAST);
      pay_nxt  = MSB_FIRST ? {pay_sh[DATA_W-2:0], MOSI} : {MOSI, pay_sh[DATA_W-1:1]};
      tx_nxt   = MSB_FIRST ? {tx_sh[DATA_W-2:0], 1'b0} : {1'b0, tx_sh[DATA_W-1:1]};
      tx_bit   = MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0];
   end

   assign busy = (state != IDLE);

   // cmd bits always arrive first and MSB first; only the payload follows MSB_FIRST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase        <= PH_RX;
         cnt          <= '0;
         wcnt         <= '0;
         cmd_sh       <= '0;
         pay_sh       <= '0;
         tx_sh        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         MISO         <= 1'b0;
         rd_addr_seen <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         MISO     <= 1'b0;
         if (SS_n || state == CHK_CMD) begin
            phase <= PH_RX;
            cnt   <= '0;
            wcnt  <= '0;
         end else if (in_rx) begin
            if (cnt < CW'(2)) cmd_sh <= {cmd_sh[0], MOSI};
            else              pay_sh <= pay_nxt;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
               rx_data  <= {cmd_sh, pay_nxt};
               rx_valid <= 1'b1;
               cnt      <= '0;
               if (state == READ_DATA) begin
                  phase        <= PH_WAIT;
                  rd_addr_seen <= 1'b0;
               end else begin
                  phase <= PH_DONE;
                  if (state == READ_ADD) rd_addr_seen <= 1'b1;
               end
            end
         end else if (phase == PH_WAIT) begin
            if (tx_valid) begin
               tx_sh <= tx_data;
               phase <= PH_SEND;
               cnt   <= '0;
            end else if (wcnt == WLAST) begin
               phase <= PH_DONE;
            end else begin
               wcnt <= wcnt + WW'(1);
            end
         end else if (phase == PH_SEND) begin
            MISO  <= tx_bit;
            tx_sh <= tx_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == TXL) phase <= PH_DONE;
         end
      end
   end

`ifdef SPI_SLV_FRAME_ERR_EN
   // short frame: aborted with at least one, but not all, word bits shifted in
   logic err_set;
   assign err_set = SS_n ? (in_rx && cnt != '0)
                         : (phase == PH_WAIT && !tx_valid && wcnt == WLAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_err <= 1'b0;
      else        frame_err <= err_set;
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: 8-bit MSB-first instance plus a 16-bit LSB-first instance.
module tb_spi_slave_gen;

`ifdef SPI_SLV_FRAME_ERR_EN
   localparam int FE_ON = 1;
`else
   localparam int FE_ON = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        ss_n, mosi, tx_valid;
   logic [7:0]  tx_data;
   logic        miso, rx_valid, busy, frame_err;
   logic [9:0]  rx_data;

   logic        ss_n2, mosi2, tx_valid2;
   logic [15:0] tx_data2;
   logic        miso2, rx_valid2, busy2, frame_err2;
   logic [17:0] rx_data2;

   spi_slave_gen #(.DATA_W(8), .MSB_FIRST(1'b1), .TX_WAIT_MAX(15)) dut (
      .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
      .busy(busy), .frame_err(frame_err));

   spi_slave_gen #(.DATA_W(16), .MSB_FIRST(1'b0), .TX_WAIT_MAX(15)) dut16 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss_n2), .MOSI(mosi2), .MISO(miso2),
      .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data2), .tx_valid(tx_valid2),
      .busy(busy2), .frame_err(frame_err2));

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [10:0] bits;    // select bit, cmd[1:0], payload MSB first
      logic        txv;
      logic [7:0]  txd;
      logic [9:0]  exp_rx;
      logic        exp_tx;  // MISO should carry txd
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic m, input logic tv);
      @(negedge clk);
      ss_n = s; mosi = m; tx_valid = tv;
      @(posedge clk);
      #1;
   endtask

   task automatic step16(input logic s, input logic m, input logic tv);
      @(negedge clk);
      ss_n2 = s; mosi2 = m; tx_valid2 = tv;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string nm, input logic [10:0] bits, input logic tv,
                            input logic [7:0] td, input logic [9:0] exp_rx, input logic exp_tx,
                            input int tail, input int exp_ferr);
      int pulses = 0, pedge = -1, ferr = 0;
      logic [31:0] hist = '0, exph = '0;
      logic e;
      tx_data = td;
      step(1'b0, 1'b0, tv);
      check({nm, "_busy"}, 32'(busy), 32'd1);
      for (int k = 0; k < 11; k++) begin
         step(1'b0, bits[10-k], tv);
         if (rx_valid) begin pulses++; pedge = k + 2; end
         ferr += int'(frame_err);
      end
      for (int t = 0; t < tail; t++) begin
         step(1'b0, 1'($urandom_range(0, 1)), tv);
         if (rx_valid) pulses++;
         ferr += int'(frame_err);
         e = 1'b0;
         if (exp_tx && t >= 1 && t <= 8) e = td[8-t];
         hist = {hist[30:0], miso};
         exph = {exph[30:0], e};
      end
      check({nm, "_pulses"}, 32'(pulses), 32'd1);
      check({nm, "_edge"}, 32'(pedge), 32'd12);
      check({nm, "_rx"}, 32'(rx_data), 32'(exp_rx));
      check({nm, "_miso"}, hist, exph);
      check({nm, "_ferr"}, 32'(ferr), 32'(exp_ferr));
   endtask

   task automatic end_frame(input string nm);
      step(1'b1, 1'b0, 1'b0);
      check({nm, "_idle"}, {30'd0, busy, miso}, 32'd0);
   endtask

   task automatic abort_frame(input string nm, input logic [10:0] bits, input int n,
                              input logic [9:0] hold, input int exp_ferr);
      int pulses = 0;
      step(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < n; k++) begin
         step(1'b0, bits[10-k], 1'b0);
         if (rx_valid) pulses++;
      end
      step(1'b1, 1'b0, 1'b0);
      if (rx_valid) pulses++;
      check({nm, "_pulses"}, 32'(pulses), 32'd0);
      check({nm, "_rx_hold"}, 32'(rx_data), 32'(hold));
      check({nm, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
      check({nm, "_idle"}, {30'd0, busy, miso}, 32'd0);
   endtask

   // 16-bit instance: select, cmd[1], cmd[0], then payload bit 0 upward; tx LSB first
   task automatic run16(input string nm, input logic sel, input logic [1:0] cmd,
                        input logic [15:0] pay, input logic tv, input logic [15:0] td,
                        input logic [17:0] exp_rx, input logic exp_tx);
      int pulses = 0, pedge = -1;
      logic [31:0] hist = '0, exph = '0;
      logic b, e;
      tx_data2 = td;
      step16(1'b0, 1'b0, tv);
      for (int k = 0; k < 19; k++) begin
         if (k == 0)      b = sel;
         else if (k == 1) b = cmd[1];
         else if (k == 2) b = cmd[0];
         else             b = pay[k-3];
         step16(1'b0, b, tv);
         if (rx_valid2) begin pulses++; pedge = k + 2; end
      end
      for (int t = 0; t < 20; t++) begin
         step16(1'b0, 1'b0, tv);
         if (rx_valid2) pulses++;
         e = 1'b0;
         if (exp_tx && t >= 1 && t <= 16) e = td[t-1];
         hist = {hist[30:0], miso2};
         exph = {exph[30:0], e};
      end
      check({nm, "_pulses"}, 32'(pulses), 32'd1);
      check({nm, "_edge"}, 32'(pedge), 32'd20);
      check({nm, "_rx"}, 32'(rx_data2), 32'(exp_rx));
      check({nm, "_miso"}, hist, exph);
      step16(1'b1, 1'b0, 1'b0);
      check({nm, "_idle"}, {30'd0, busy2, miso2}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic late_miso;
      tbl[0] = '{11'b0_00_11111111, 1'b1, 8'hAA, 10'h0FF, 1'b0};
      tbl[1] = '{11'b1_10_10100101, 1'b1, 8'hAA, 10'h2A5, 1'b0};
      tbl[2] = '{11'b1_11_00000000, 1'b1, 8'hC3, 10'h300, 1'b1};
      tbl[3] = '{11'b1_10_00111100, 1'b1, 8'hFF, 10'h23C, 1'b0};
      tbl[4] = '{11'b0_01_01011010, 1'b1, 8'h0F, 10'h15A, 1'b0};
      tbl[5] = '{11'b1_11_10000001, 1'b1, 8'h96, 10'h381, 1'b1};

      rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      ss_n2 = 1'b1; mosi2 = 1'b0; tx_valid2 = 1'b0; tx_data2 = '0;
      @(posedge clk); @(posedge clk); #1;
      check("reset8", 32'({miso, rx_valid, busy, frame_err, rx_data}), 32'd0);
      check("reset16", 32'({miso2, rx_valid2, busy2, frame_err2, rx_data2}), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_frame($sformatf("vec%0d", i), tbl[i].bits, tbl[i].txv, tbl[i].txd,
                   tbl[i].exp_rx, tbl[i].exp_tx, 12, 0);
         end_frame($sformatf("vec%0d", i));
      end

      abort_frame("abort_w5", 11'b0_00_11111111, 5, 10'h381, FE_ON);
      abort_frame("abort_last", 11'b0_00_10101010, 10, 10'h381, FE_ON);
      abort_frame("abort_sel", 11'b0_00_11111111, 1, 10'h381, 0);

      run_frame("addr_a", 11'b1_10_00010001, 1'b0, 8'h00, 10'h211, 1'b0, 2, 0);
      end_frame("addr_a");
      abort_frame("abort_rd", 11'b1_11_11111111, 6, 10'h211, FE_ON);
      run_frame("data_a", 11'b1_11_00100010, 1'b1, 8'h5A, 10'h322, 1'b1, 12, 0);
      end_frame("data_a");

      run_frame("addr_t", 11'b1_10_00110011, 1'b0, 8'h00, 10'h233, 1'b0, 2, 0);
      end_frame("addr_t");
      run_frame("tmo", 11'b1_11_01000100, 1'b0, 8'hFF, 10'h344, 1'b0, 20, FE_ON);
      check("tmo_busy", 32'(busy), 32'd1);
      late_miso = 1'b0;
      tx_data = 8'hFF;
      for (int t = 0; t < 5; t++) begin
         step(1'b0, 1'b1, 1'b1);
         late_miso |= miso;
      end
      check("tmo_late_miso", 32'(late_miso), 32'd0);
      end_frame("tmo");

      run_frame("addr_r", 11'b1_10_01010101, 1'b0, 8'h00, 10'h255, 1'b0, 2, 0);
      end_frame("addr_r");
      run_frame("data_r", 11'b1_11_01100110, 1'b1, 8'hFF, 10'h366, 1'b1, 4, 0);
      check("pre_reset_miso", 32'(miso), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("async_reset", 32'({miso, rx_valid, busy, frame_err, rx_data}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; ss_n = 1'b1;
      run_frame("post_reset", 11'b1_11_01110111, 1'b1, 8'hC3, 10'h377, 1'b0, 12, 0);
      end_frame("post_reset");

      run16("w16", 1'b0, 2'b00, 16'h1234, 1'b1, 16'hFFFF, 18'h01234, 1'b0);
      run16("a16", 1'b1, 2'b10, 16'h00F0, 1'b0, 16'h0000, 18'h200F0, 1'b0);
      run16("d16", 1'b1, 2'b11, 16'hABCD, 1'b1, 16'h0003, 18'h3ABCD, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
